if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the PC generator. Each cycle it issues the
//  generator's pc to instruction memory and tags the request with that pc.
//  Returned instructions are buffered in order in a DEPTH-entry queue, and
//  {pc, instr} pairs are presented to decode over a valid/ready handshake.
//  It drives stall back to the PC generator and discards wrong-path fetches on flush.
// PARAMETERS
//  XLEN   32  data/address width
//  DEPTH  4   queue entries; power of 2, >=2; also the cap on in-flight requests
// PORTS
//  clk              in   1     clock
//  reset            in   1     synchronous, active-high
//  pc               in   XLEN  current fetch address from PC generator
//  flush            in   1     taken branch/jump (beq|bneq|bge|ble|jump) this cycle
//  stall            out  1     hold pc; PC generator keeps pc when 1
//  imem_req_valid   out  1     fetch request valid
//  imem_req_ready   in   1     memory accepts request
//  imem_addr        out  XLEN  = pc
//  imem_resp_valid  in   1     instruction returned (in order, >=1 cycle after accept)
//  imem_resp_data   in   XLEN  instruction word
//  id_valid         out  1     head entry holds a returned instruction
//  id_ready         in   1     decode consumes head
//  id_pc            out  XLEN  pc of head entry
//  id_instr         out  XLEN  instruction of head entry
// BEHAVIOUR
//  State:
//  - ring of DEPTH entries {pc, instr, filled}; pointers alloc_ptr, fill_ptr, rd_ptr
//  - occ: allocated entries, 0..DEPTH; drop_cnt: responses still to discard, 0..DEPTH
//  Reset: all pointers/counters 0, all filled=0; outputs imem_req_valid=0, id_valid=0, stall=0.
//  Request:
//  - imem_req_valid = !reset & !flush & (occ+drop_cnt < DEPTH); imem_addr = pc
//  - accept = imem_req_valid & imem_req_ready
//  - on accept: entry[alloc_ptr] <= {pc, filled=0}; alloc_ptr++ (wraps mod DEPTH); occ++
//  - stall = !flush & !accept; combinational on imem_req_ready.
//    The PC generator advances exactly once per accepted request.
//  Response:
//  - discarded if flush | drop_cnt!=0 (drop_cnt-- when !flush)
//  - otherwise entry[fill_ptr].instr <= data, filled=1, fill_ptr++
//  - a response with no unfilled allocated entry and drop_cnt==0 is a protocol
//    error: ignored, flagged by assertion
//  Dequeue:
//  - id_valid = entry[rd_ptr].filled; pop = id_valid & id_ready
//  - on pop: filled=0, rd_ptr++, occ--
//  - 0-cycle bypass: none. Min latency accept->id_valid = mem latency + 1.
//  Flush (highest priority after reset):
//  - clears all entries and pointers; occ<=0; no request issued; no pop counted
//  - drop_cnt <= (allocated-unfilled + drop_cnt) - (imem_resp_valid ? 1 : 0)
//  - stall forced 0 so the PC generator takes its redirect; target fetched next cycle
//  Boundaries:
//  - full (occ+drop_cnt==DEPTH): no request, stall=1
//  - simultaneous accept+pop at full-1 / pop at full: both take effect; occ net 0
//  - simultaneous response+pop on same entry cannot occur (pop requires filled)
//  - reset mid-flight: in-flight responses after reset are not dropped;
//    the memory is reset in the same cycle by contract
// STRUCTURE
//  riscv_pkg:
//  - XLEN
//  - typedef fetch_entry_t {pc, instr, filled}
//  - NOP_INSTR = 32'h0000_0013
//  Sub-module ifq_ring:
//  - storage and pointers, one write-alloc, one fill, one read port
//  - counters and handshake logic stay in the top
// TESTING
//  1. reset 3 cycles, mem latency 1, id_ready=1:
//     -> imem_addr 0,4,8,...; id_pc/id_instr in order; stall=0 steady
//  2. id_ready=0, DEPTH=4:
//     -> 4 accepts then stall=1, pc held at 0x10; release -> resumes at 0x10, no loss/dup
//  3. imem_req_ready=0 for 3 cycles:
//     -> stall=1 for 3 cycles, imem_addr held; no entry allocated
//  4. flush with 2 in flight (latency 3):
//     -> both responses dropped (drop_cnt 2->0); next id_pc = target
//  5. flush same cycle as response and pop:
//     -> response dropped, queue empty, stall=0, no request that cycle
//  6. reset asserted with queue full:
//     -> next cycle id_valid=0, occ=0, first request addr 0 after release

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entries carry the fetch pc, the returned word and a filled flag.
package if_fetch_queue_pkg;

  localparam int XLEN = 32;

  // Canonical RISC-V nop (addi x0, x0, 0), shown on id_instr while the head is empty.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage : if_fetch_queue_pkg

// File: rtl/if_fetch_queue_if.sv
// Bundle of PC-generator, instruction-memory and decode signals around the fetch queue.
// master = fetch queue side, slave = surrounding pipeline/memory side.
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic [XLEN-1:0] pc;
  logic            flush;
  logic            stall;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    input  pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output stall, imem_req_valid, imem_addr, id_valid, id_pc, id_instr
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  stall, imem_req_valid, imem_addr, id_valid, id_pc, id_instr
  );

endinterface : if_fetch_queue_if

// File: rtl/if_fetch_queue_ring.sv
// Ring storage for the fetch queue: one allocate port (pc), one fill port (instr),
// one read/pop port at the head. Occupancy accounting lives in the parent.
module ifq_ring
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_i,
  input  logic            alloc_en_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_en_i,
  input  logic [XLEN-1:0] fill_instr_i,
  input  logic            pop_en_i,
  output fetch_entry_t    head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]    fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [DEPTH-1:0] filled_q,    filled_d;

  logic [XLEN-1:0]  pc_mem_q    [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    filled_d    = filled_q;

    if (alloc_en_i) begin
      filled_d[alloc_ptr_q] = 1'b0;
      alloc_ptr_d           = alloc_ptr_q + PW'(1);
    end
    if (fill_en_i) begin
      filled_d[fill_ptr_q] = 1'b1;
      fill_ptr_d           = fill_ptr_q + PW'(1);
    end
    if (pop_en_i) begin
      filled_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PW'(1);
    end

    // A flush wipes everything in flight; it wins over any same-cycle update.
    if (clear_i) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      filled_d    = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      filled_q    <= filled_d;
    end
  end

  // NOTE: payload arrays are not reset; the filled bits gate their visibility, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (alloc_en_i) pc_mem_q[alloc_ptr_q]   <= alloc_pc_i;
    if (fill_en_i)  instr_mem_q[fill_ptr_q] <= fill_instr_i;
  end

  always_comb begin
    head_o.filled = filled_q[rd_ptr_q];
    head_o.pc     = pc_mem_q[rd_ptr_q];
    head_o.instr  = filled_q[rd_ptr_q] ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  end

endmodule : ifq_ring

// File: rtl/if_fetch_queue.sv
// Fetch stage: issues pc to instruction memory, buffers in-order responses and
// hands {pc, instr} to decode; drops wrong-path responses after a flush.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] occ_q,  occ_d;   // allocated entries
  logic [CW-1:0] pend_q, pend_d;  // allocated but not yet filled
  logic [CW-1:0] drop_q, drop_d;  // responses still owed to flushed requests
  logic [CW:0]   in_use;
  logic [CW:0]   lost;

  logic         req_valid;
  logic         accept;
  logic         fill;
  logic         pop;
  fetch_entry_t head;

  // Dropped-but-outstanding responses still reserve capacity in the memory pipe.
  assign in_use    = {1'b0, occ_q} + {1'b0, drop_q};
  assign req_valid = !reset && !bus.flush && (in_use < (CW+1)'(DEPTH));
  assign accept    = req_valid && bus.imem_req_ready;
  assign fill      = bus.imem_resp_valid && !bus.flush && (drop_q == '0) && (pend_q != '0);
  assign pop       = head.filled && bus.id_ready && !bus.flush;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = bus.pc;
  // Released on flush so the PC generator can take its redirect.
  assign bus.stall          = !reset && !bus.flush && !accept;
  assign bus.id_valid       = head.filled;
  assign bus.id_pc          = head.pc;
  assign bus.id_instr       = head.instr;

  always_comb begin
    occ_d  = occ_q;
    pend_d = pend_q;
    drop_d = drop_q;
    lost   = {1'b0, pend_q} + {1'b0, drop_q};

    if (bus.flush) begin
      // Everything not yet returned becomes debt; a response arriving now pays one off.
      if (bus.imem_resp_valid && (lost != '0)) lost = lost - (CW+1)'(1);
      occ_d  = '0;
      pend_d = '0;
      drop_d = lost[CW-1:0];
    end else begin
      occ_d  = occ_q  + CW'(accept) - CW'(pop);
      pend_d = pend_q + CW'(accept) - CW'(fill);
      if (bus.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= '0;
      pend_q <= '0;
      drop_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  ifq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (bus.flush),
    .alloc_en_i   (accept),
    .alloc_pc_i   (bus.pc),
    .fill_en_i    (fill),
    .fill_instr_i (bus.imem_resp_data),
    .pop_en_i     (pop),
    .head_o       (head)
  );

  // A response with nothing outstanding means the memory broke the in-order contract.
  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
    !(bus.imem_resp_valid && (pend_q == '0) && (drop_q == '0)));

endmodule : if_fetch_queue
